// File: rtl/uart_trig_pkg.sv
// Shared types for the UART sequence trigger: receiver FSM states and the
// masked word compare used by the sequence matcher.
package uart_trig_pkg;

  // Widest supported data word; narrower words are zero-extended before compare.
  localparam int MATCH_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Zero-extended upper bits compare equal, so they never block a match.
  function automatic logic word_match(input logic [MATCH_W-1:0] w,
                                      input logic [MATCH_W-1:0] m,
                                      input logic [MATCH_W-1:0] mk);
    return &((w ~^ m) | mk);
  endfunction

endpackage

// File: rtl/uart_seq_trig_rx_if.sv
// Serial line, matcher programming and received-word reporting for the
// UART sequence trigger; master drives the line and configuration.
interface uart_seq_trig_rx_if #(
  parameter int DATA_BITS = 8,
  parameter int SEQ_LEN   = 2,
  parameter int BAUD_W    = 16,
  parameter int IDX_W     = $clog2(SEQ_LEN + 1)
);
  logic                           RX;
  logic [BAUD_W-1:0]              baud_cnt;
  logic [SEQ_LEN*DATA_BITS-1:0]   match;
  logic [SEQ_LEN*DATA_BITS-1:0]   mask;
  logic                           armed;
  logic                           UARTtrig;
  logic [DATA_BITS-1:0]           rx_data;
  logic                           rx_rdy;
  logic                           frame_err;
  logic                           parity_err;
  logic [IDX_W-1:0]               seq_idx;

  modport master (
    output RX, baud_cnt, match, mask, armed,
    input  UARTtrig, rx_data, rx_rdy, frame_err, parity_err, seq_idx
  );

  modport slave (
    input  RX, baud_cnt, match, mask, armed,
    output UARTtrig, rx_data, rx_rdy, frame_err, parity_err, seq_idx
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART frame receiver: synchroniser, baud timing, frame FSM, parity and stop
// checks. Result strobes are asserted in the stop-sample cycle.
module uart_rx_frame
  import uart_trig_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int BAUD_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic [BAUD_W-1:0]    baud_cnt,
  output logic [DATA_BITS-1:0] word,
  output logic                 word_vld,
  output logic                 ferr,
  output logic                 perr
);

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  logic [BAUD_W-1:0]    cnt;
  logic [BAUD_W-1:0]    bd_q;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q;
  logic                 stop_pt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // The counter restarts at 1 on each event so the next sample lands exactly bd_q clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bd_q    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      perr_q  <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            cnt    <= BAUD_W'(1);
            bd_q   <= baud_cnt;
            perr_q <= 1'b0;
          end
        end
        START: begin
          if (cnt == (bd_q >> 1)) begin
            cnt     <= BAUD_W'(1);
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == bd_q) begin
            cnt     <= BAUD_W'(1);
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 4'(DATA_BITS - 1))
              state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (cnt == bd_q) begin
            cnt    <= BAUD_W'(1);
            perr_q <= ((^shreg) ^ rx_s) != 1'(PARITY_ODD);
            state  <= STOP;
          end
        end
        STOP: begin
          if (cnt == bd_q) begin
            cnt   <= BAUD_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_pt  = (state == STOP) && (cnt == bd_q);
  assign word     = shreg;
  assign word_vld = stop_pt && rx_s && !perr_q;
  assign ferr     = stop_pt && !rx_s;
  assign perr     = stop_pt && perr_q;

endmodule

// File: rtl/uart_seq_trig_rx.sv
// UART receive trigger: frames words via uart_rx_frame and fires a one-cycle
// trigger when SEQ_LEN consecutive good words match the masked sequence.
module uart_seq_trig_rx
  import uart_trig_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int SEQ_LEN    = 2,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int BAUD_W     = 16
) (
  input logic               clk,
  input logic               rst_n,
  uart_seq_trig_rx_if.slave bus
);

  localparam int IDX_W = $clog2(SEQ_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

  logic [DATA_BITS-1:0] word;
  logic                 word_vld;
  logic                 ferr;
  logic                 perr;
  logic                 hit_cur;
  logic                 hit_first;
  logic [IDX_W-1:0]     seq_idx_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 rdy_q;
  logic                 trig_q;
  logic                 ferr_q;
  logic                 perr_q;

  uart_rx_frame #(
    .DATA_BITS (DATA_BITS),
    .PARITY_EN (PARITY_EN),
    .PARITY_ODD(PARITY_ODD),
    .BAUD_W    (BAUD_W)
  ) u_frame (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (bus.RX),
    .baud_cnt(bus.baud_cnt),
    .word    (word),
    .word_vld(word_vld),
    .ferr    (ferr),
    .perr    (perr)
  );

  always_comb begin
    hit_cur   = word_match(MATCH_W'(word),
                           MATCH_W'(bus.match[int'(seq_idx_q)*DATA_BITS +: DATA_BITS]),
                           MATCH_W'(bus.mask[int'(seq_idx_q)*DATA_BITS +: DATA_BITS]));
    hit_first = word_match(MATCH_W'(word),
                           MATCH_W'(bus.match[DATA_BITS-1:0]),
                           MATCH_W'(bus.mask[DATA_BITS-1:0]));
  end

  // A mismatch that still matches word 0 restarts the sequence at index 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_idx_q <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      trig_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      rdy_q  <= word_vld;
      ferr_q <= ferr;
      perr_q <= perr;
      trig_q <= 1'b0;
      if (word_vld)
        data_q <= word;
      if (!bus.armed || ferr || perr) begin
        seq_idx_q <= '0;
      end else if (word_vld) begin
        if (hit_cur && seq_idx_q == LAST_IDX) begin
          trig_q    <= 1'b1;
          seq_idx_q <= '0;
        end else if (hit_cur) begin
          seq_idx_q <= seq_idx_q + 1'b1;
        end else if (hit_first) begin
          seq_idx_q <= IDX_W'(1);
        end else begin
          seq_idx_q <= '0;
        end
      end
    end
  end

  assign bus.UARTtrig   = trig_q;
  assign bus.rx_data    = data_q;
  assign bus.rx_rdy     = rdy_q;
  assign bus.frame_err  = ferr_q;
  assign bus.parity_err = perr_q;
  assign bus.seq_idx    = seq_idx_q;

endmodule

// File: tb/tb_uart_seq_trig_rx.sv
// Self-checking bench: DUT A (SEQ_LEN=1, no parity) and DUT B (SEQ_LEN=2,
// even parity) driven with serial frames and checked against a word-level model.
module tb_uart_seq_trig_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_seq_trig_rx_if #(.DATA_BITS(8), .SEQ_LEN(1), .BAUD_W(16)) ifa ();
  uart_seq_trig_rx_if #(.DATA_BITS(8), .SEQ_LEN(2), .BAUD_W(16)) ifb ();

  uart_seq_trig_rx #(.DATA_BITS(8), .SEQ_LEN(1), .PARITY_EN(0), .PARITY_ODD(0), .BAUD_W(16))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  uart_seq_trig_rx #(.DATA_BITS(8), .SEQ_LEN(2), .PARITY_EN(1), .PARITY_ODD(0), .BAUD_W(16))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Event log: every rx_rdy cycle is recorded with its data, trigger and new index.
  logic [7:0] qa_data[$];
  bit         qa_trig[$];
  logic [7:0] qb_data[$];
  bit         qb_trig[$];
  logic [1:0] qb_idx[$];
  int a_trig_n = 0, b_trig_n = 0, b_ferr_n = 0, b_perr_n = 0, a_err_n = 0;
  int lone_n = 0, long_n = 0;
  logic [7:0] prev_a = '0, prev_b = '0;

  always @(negedge clk) begin
    if (ifa.rx_rdy) begin
      qa_data.push_back(ifa.rx_data);
      qa_trig.push_back(ifa.UARTtrig);
    end
    if (ifb.rx_rdy) begin
      qb_data.push_back(ifb.rx_data);
      qb_trig.push_back(ifb.UARTtrig);
      qb_idx.push_back(ifb.seq_idx);
    end
    if (ifa.UARTtrig) a_trig_n++;
    if (ifb.UARTtrig) b_trig_n++;
    if (ifb.frame_err) b_ferr_n++;
    if (ifb.parity_err) b_perr_n++;
    if (ifa.frame_err || ifa.parity_err) a_err_n++;
    if ((ifa.UARTtrig && !ifa.rx_rdy) || (ifb.UARTtrig && !ifb.rx_rdy)) lone_n++;
    if ((({ifa.rx_rdy, ifa.UARTtrig, ifa.frame_err, ifa.parity_err} & prev_a[3:0]) != 4'b0) ||
        (({ifb.rx_rdy, ifb.UARTtrig, ifb.frame_err, ifb.parity_err} & prev_b[3:0]) != 4'b0))
      long_n++;
    prev_a = {4'b0, ifa.rx_rdy, ifa.UARTtrig, ifa.frame_err, ifa.parity_err};
    prev_b = {4'b0, ifb.rx_rdy, ifb.UARTtrig, ifb.frame_err, ifb.parity_err};
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit sel_b, input bit v, input int n);
    @(negedge clk);
    if (sel_b) ifb.RX = v;
    else ifa.RX = v;
    repeat (n - 1) @(negedge clk);
  endtask

  // One serial frame; a low stop bit is followed by two idle bit times.
  task automatic applyStimulus(input bit sel_b, input logic [7:0] w, input bit par,
                               input bit stop, input int bd);
    drive(sel_b, 1'b0, bd);
    for (int i = 0; i < 8; i++) drive(sel_b, w[i], bd);
    if (sel_b) drive(sel_b, par, bd);
    drive(sel_b, stop, bd);
    if (!stop) drive(sel_b, 1'b1, 2 * bd);
  endtask

  task automatic send_a(input logic [7:0] w);
    applyStimulus(1'b0, w, 1'b0, 1'b1, 16);
  endtask

  task automatic send_b(input logic [7:0] w);
    applyStimulus(1'b1, w, ^w, 1'b1, 16);
  endtask

  function automatic bit hit(input logic [7:0] w, input logic [7:0] m, input logic [7:0] mk);
    return ((w ^ m) & ~mk) == 8'h00;
  endfunction

  task automatic test_reset();
    ifa.RX = 1'b1; ifb.RX = 1'b1;
    ifa.baud_cnt = 16'd16; ifb.baud_cnt = 16'd16;
    ifa.match = '0; ifa.mask = '0; ifb.match = '0; ifb.mask = '0;
    ifa.armed = 1'b1; ifb.armed = 1'b1;
    #2 rst_n = 1'b0;
    settle(3);
    total++; if (ifa.rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_a_data: got %0h want 0", ifa.rx_data); end
    total++; if ({ifa.rx_rdy, ifa.UARTtrig, ifa.frame_err, ifa.parity_err, ifa.seq_idx} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_a_flags: got %b want 0", {ifa.rx_rdy, ifa.UARTtrig, ifa.frame_err, ifa.parity_err, ifa.seq_idx}); end
    total++; if (ifb.rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_b_data: got %0h want 0", ifb.rx_data); end
    total++; if ({ifb.rx_rdy, ifb.UARTtrig, ifb.frame_err, ifb.parity_err, ifb.seq_idx} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_b_flags: got %b want 0", {ifb.rx_rdy, ifb.UARTtrig, ifb.frame_err, ifb.parity_err, ifb.seq_idx}); end
    @(negedge clk) rst_n = 1'b1;
    settle(4);
  endtask

  task automatic test_single_word();
    int n;
    logic [7:0] m, mk, w;
    bit exp_t;
    ifa.match = 8'h05; ifa.mask = 8'h40;
    n = qa_data.size();
    send_a(8'h45); settle(4);
    total++; if (qa_data.size() !== n + 1 || qa_data[n] !== 8'h45) begin bad++; $display("[TB] FAIL single_data: got %0h want 45", qa_data[n]); end
    total++; if (qa_trig[n] !== 1'b1) begin bad++; $display("[TB] FAIL single_trig: got %0b want 1", qa_trig[n]); end
    send_a(8'h44); settle(4);
    total++; if (qa_data.size() !== n + 2 || qa_trig[n+1] !== 1'b0) begin bad++; $display("[TB] FAIL single_notrig: got %0b want 0", qa_trig[n+1]); end
    for (int i = 0; i < 6; i++) begin
      m = 8'($urandom); mk = 8'($urandom & $urandom);
      w = ($urandom_range(0, 1) == 1) ? (m ^ (8'($urandom) & mk)) : 8'($urandom);
      exp_t = hit(w, m, mk);
      ifa.match = m; ifa.mask = mk;
      n = qa_data.size();
      send_a(w); settle(4);
      total++; if (qa_data[n] !== w) begin bad++; $display("[TB] FAIL rand_a_data: got %0h want %0h", qa_data[n], w); end
      total++; if (qa_trig[n] !== exp_t) begin bad++; $display("[TB] FAIL rand_a_trig: got %0b want %0b", qa_trig[n], exp_t); end
    end
  endtask

  task automatic test_sequence();
    int n, t0;
    logic [7:0] words[3] = '{8'h55, 8'h55, 8'hAA};
    logic [1:0] exp_idx[3] = '{2'd1, 2'd1, 2'd0};
    bit exp_trig[3] = '{1'b0, 1'b0, 1'b1};
    ifb.match = {8'hAA, 8'h55}; ifb.mask = '0;
    n = qb_data.size(); t0 = b_trig_n;
    for (int i = 0; i < 3; i++) send_b(words[i]);
    settle(4);
    for (int i = 0; i < 3; i++) begin
      total++; if (qb_idx[n+i] !== exp_idx[i] || qb_trig[n+i] !== exp_trig[i]) begin
        bad++; $display("[TB] FAIL seq_step%0d: got idx=%0d trig=%0b want idx=%0d trig=%0b", i, qb_idx[n+i], qb_trig[n+i], exp_idx[i], exp_trig[i]); end
    end
    total++; if (b_trig_n - t0 !== 1) begin bad++; $display("[TB] FAIL seq_trig_count: got %0d want 1", b_trig_n - t0); end
  endtask

  task automatic test_back_to_back();
    int n, idx;
    logic [7:0] m[2], mk[2], w;
    logic [7:0] ws[$];
    bit et[$];
    int ei[$];
    bit hc;
    m[0] = 8'($urandom); m[1] = 8'($urandom);
    mk[0] = 8'($urandom & $urandom & $urandom); mk[1] = 8'($urandom & $urandom & $urandom);
    ifb.match = {m[1], m[0]}; ifb.mask = {mk[1], mk[0]};
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 2))
        0: w = m[0] ^ (8'($urandom) & mk[0]);
        1: w = m[1] ^ (8'($urandom) & mk[1]);
        default: w = 8'($urandom);
      endcase
      ws.push_back(w);
      hc = hit(w, m[idx], mk[idx]);
      if (hc && idx == 1) begin et.push_back(1'b1); idx = 0; end
      else begin
        et.push_back(1'b0);
        if (hc) idx = idx + 1;
        else if (hit(w, m[0], mk[0])) idx = 1;
        else idx = 0;
      end
      ei.push_back(idx);
    end
    n = qb_data.size();
    foreach (ws[i]) send_b(ws[i]);
    settle(4);
    foreach (ws[i]) begin
      total++; if (qb_data[n+i] !== ws[i] || qb_trig[n+i] !== et[i] || int'(qb_idx[n+i]) !== ei[i]) begin
        bad++; $display("[TB] FAIL b2b_word%0d: got data=%0h trig=%0b idx=%0d want data=%0h trig=%0b idx=%0d",
                        i, qb_data[n+i], qb_trig[n+i], qb_idx[n+i], ws[i], et[i], ei[i]); end
    end
  endtask

  task automatic test_parity();
    int n, p0;
    ifb.match = {8'hAA, 8'h55}; ifb.mask = '0;
    send_b(8'h55); settle(4);
    n = qb_data.size(); p0 = b_perr_n;
    applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 16); settle(4);
    total++; if (b_perr_n - p0 !== 1 || qb_data.size() !== n) begin
      bad++; $display("[TB] FAIL parity_err: got perr=%0d rdy=%0d want perr=1 rdy=0", b_perr_n - p0, qb_data.size() - n); end
    total++; if (ifb.seq_idx !== 2'd0 || ifb.rx_data !== 8'h55) begin
      bad++; $display("[TB] FAIL parity_state: got idx=%0d data=%0h want idx=0 data=55", ifb.seq_idx, ifb.rx_data); end
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b1, 16); settle(4);
    total++; if (qb_data.size() !== n + 1 || qb_data[n] !== 8'h03) begin
      bad++; $display("[TB] FAIL parity_ok: got %0h want 03", qb_data[n]); end
  endtask

  task automatic test_frame_err();
    int n, f0, p0, t0;
    send_b(8'h55); settle(4);
    n = qb_data.size(); f0 = b_ferr_n; p0 = b_perr_n; t0 = b_trig_n;
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 16); settle(4);
    total++; if (b_ferr_n - f0 !== 1 || b_perr_n != p0 || qb_data.size() !== n || b_trig_n != t0) begin
      bad++; $display("[TB] FAIL frame_err: got ferr=%0d perr=%0d rdy=%0d trig=%0d want 1 0 0 0",
                      b_ferr_n - f0, b_perr_n - p0, qb_data.size() - n, b_trig_n - t0); end
    total++; if (ifb.rx_data !== 8'h55 || ifb.seq_idx !== 2'd0) begin
      bad++; $display("[TB] FAIL frame_state: got data=%0h idx=%0d want 55 0", ifb.rx_data, ifb.seq_idx); end
    send_b(8'h55); send_b(8'hAA); settle(4);
    total++; if (qb_data.size() !== n + 2 || qb_idx[n] !== 2'd1 || qb_trig[n+1] !== 1'b1) begin
      bad++; $display("[TB] FAIL frame_recover: got idx=%0d trig=%0b want 1 1", qb_idx[n], qb_trig[n+1]); end
  endtask

  task automatic test_glitch_baud();
    int n, f0, p0;
    n = qb_data.size(); f0 = b_ferr_n; p0 = b_perr_n;
    drive(1'b1, 1'b0, 4); drive(1'b1, 1'b1, 48);
    total++; if (qb_data.size() != n || b_ferr_n != f0 || b_perr_n != p0) begin
      bad++; $display("[TB] FAIL glitch: got events=%0d want 0", (qb_data.size() - n) + (b_ferr_n - f0) + (b_perr_n - p0)); end
    send_b(8'h5A); settle(4);
    total++; if (qb_data.size() !== n + 1 || qb_data[n] !== 8'h5A) begin
      bad++; $display("[TB] FAIL glitch_next: got %0h want 5a", qb_data[n]); end
    fork
      send_b(8'h3C);
      begin settle(40); ifb.baud_cnt = 16'd32; end
    join
    ifb.baud_cnt = 16'd16;
    settle(4);
    total++; if (qb_data.size() !== n + 2 || qb_data[n+1] !== 8'h3C) begin
      bad++; $display("[TB] FAIL baud_change: got %0h want 3c", qb_data[n+1]); end
  endtask

  task automatic test_armed();
    int n, t0;
    ifb.match = {8'hAA, 8'h55}; ifb.mask = '0;
    ifb.armed = 1'b0;
    n = qb_data.size(); t0 = b_trig_n;
    send_b(8'h55); send_b(8'hAA); settle(4);
    total++; if (b_trig_n != t0 || qb_idx[n] !== 2'd0 || qb_idx[n+1] !== 2'd0 || qb_data[n+1] !== 8'hAA) begin
      bad++; $display("[TB] FAIL disarmed: got trig=%0d idx=%0d,%0d want 0 0,0", b_trig_n - t0, qb_idx[n], qb_idx[n+1]); end
    ifb.armed = 1'b1;
    send_b(8'h55); send_b(8'hAA); settle(4);
    total++; if (b_trig_n - t0 !== 1 || qb_trig[n+3] !== 1'b1) begin
      bad++; $display("[TB] FAIL rearmed: got trig=%0d want 1", b_trig_n - t0); end
  endtask

  task automatic test_reset_mid();
    int n;
    send_b(8'h55); settle(4);
    drive(1'b1, 1'b0, 16); drive(1'b1, 1'b1, 16); drive(1'b1, 1'b0, 16);
    rst_n = 1'b0;
    settle(2);
    total++; if (ifb.rx_data !== 8'h00 || {ifb.rx_rdy, ifb.UARTtrig, ifb.frame_err, ifb.parity_err, ifb.seq_idx} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_mid: got data=%0h idx=%0d want 0 0", ifb.rx_data, ifb.seq_idx); end
    ifb.RX = 1'b1;
    rst_n = 1'b1;
    settle(48);
    n = qb_data.size();
    send_b(8'hC3); settle(4);
    total++; if (qb_data.size() !== n + 1 || qb_data[n] !== 8'hC3 || qb_idx[n] !== 2'd0) begin
      bad++; $display("[TB] FAIL reset_recover: got data=%0h idx=%0d want c3 0", qb_data[n], qb_idx[n]); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_sequence();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_glitch_baud();
    test_armed();
    test_reset_mid();
    total++; if (lone_n != 0 || long_n != 0 || a_err_n != 0) begin
      bad++; $display("[TB] FAIL pulse_shape: got lone=%0d long=%0d aerr=%0d want 0", lone_n, long_n, a_err_n); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_seq_trig_rx.md
Name: uart_seq_trig_rx

Overview:
Parametrised UART receive trigger for the logic-analyser trigger path. It receives UART frames with configurable data width and optional parity, then matches a programmable sequence of SEQ_LEN masked words against consecutive received words. On a full-sequence match it emits a single-cycle trigger. It also reports each received word and any framing or parity errors.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
SEQ_LEN, 2, number of consecutive words in the trigger sequence (1..8)
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, parity sense when PARITY_EN=1 (0 even, 1 odd)
BAUD_W, 16, width of the baud divisor

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
RX  in  1  asynchronous serial input, idle high
baud_cnt  in  BAUD_W  clocks per bit; legal values are >= 4
match  in  SEQ_LEN*DATA_BITS  expected words; word k occupies bits [k*DATA_BITS +: DATA_BITS]; word 0 is first in time
mask  in  SEQ_LEN*DATA_BITS  per-bit don't-care; 1 = ignore that bit
armed  in  1  0 = matcher held at index 0, so no trigger can fire; reception continues
UARTtrig  out  1  1-cycle pulse on a full sequence match
rx_data  out  DATA_BITS  last good word; holds its value between frames
rx_rdy  out  1  1-cycle pulse when rx_data updates
frame_err  out  1  1-cycle pulse when the stop bit samples low
parity_err  out  1  1-cycle pulse on a parity mismatch
seq_idx  out  clog2(SEQ_LEN+1)  current matcher index, for debug

Behaviour:
- Reset: clk and rst_n as decided (clock clk; reset rst_n, asynchronous, active-low).
- Reset values: both RX synchroniser flops = 1; state = IDLE; rx_data = 0; all pulse outputs = 0; seq_idx = 0.
- RX passes through two flops (rx_s); all logic uses rx_s only.
- Baud divisor: baud_cnt is latched into bd_q on start detect, so a change mid-frame has no effect until the next frame.
- Bit counter: a BAUD_W-bit counter is cleared on each sample point.
- FSM states:
  - IDLE: when rx_s = 0, go to START and clear the counter.
  - START: on counter == bd_q>>1 (mid start bit), sample rx_s. If 1, treat as a glitch and return to IDLE with no outputs. If 0, go to DATA with bit index 0.
  - DATA: on counter == bd_q, shift rx_s into the MSB of a DATA_BITS shift register. After the DATA_BITS-th sample, go to PARITY if PARITY_EN = 1, otherwise go to STOP.
  - PARITY: on counter == bd_q, sample the parity bit. perr = (XOR of data XOR parity bit) != PARITY_ODD. Go to STOP.
  - STOP: on counter == bd_q, sample the stop bit and go to IDLE.
- Stop bit sampled 1 (next cycle):
  - If no parity error: rx_data updates and rx_rdy pulses.
  - If a parity error: parity_err pulses instead; rx_data is unchanged and there is no rx_rdy.
- Stop bit sampled 0: frame_err pulses; rx_data is unchanged. If a parity error is also present, parity_err pulses in the same cycle.
- Return to IDLE after STOP happens in the same cycle as the stop sample, so back-to-back frames are received.
- Match function: word w matches entry k when &((w ~^ match[k]) | mask[k]) = 1.
- Matcher update, evaluated only on a good word (the rx_rdy cycle):
  - If w matches entry seq_idx and seq_idx == SEQ_LEN-1: UARTtrig pulses in the same cycle as rx_rdy, and seq_idx goes to 0.
  - Else if w matches entry seq_idx: seq_idx increments.
  - Else if w matches entry 0: seq_idx = 1 (for SEQ_LEN = 1 this case is unreachable).
  - Else: seq_idx = 0.
- Any frame_err or parity_err sets seq_idx to 0.
- armed = 0 forces seq_idx to 0 and suppresses UARTtrig. armed rising takes effect from the next word.
- Latency: rx_rdy and UARTtrig occur 1 clock after the stop sample point, about 2 clocks of synchroniser delay plus (DATA_BITS + PARITY_EN + 1.5) * baud_cnt clocks after the RX falling edge.
- Reset asserted mid-frame returns everything to reset values immediately. After release, a line already low is treated as a new start, and the START glitch check applies.
- The output pulses never stay high for more than one cycle.

Decomposition:
- Shared package uart_trig_pkg: state enum (IDLE, START, DATA, PARITY, STOP) and the masked-match function.
- One sub-module, uart_rx_frame: synchroniser, baud counter, FSM, shift register, parity and stop check. It outputs word, word_vld, ferr, perr.
- The top level holds the sequence matcher and the output registers.

Test Plan:
- SEQ_LEN=1, baud_cnt=16, match=0x05, mask=0x40, send 0x45 -> rx_rdy with rx_data=0x45 and UARTtrig in the same cycle. Then send 0x44 -> rx_rdy only.
- SEQ_LEN=2, match={0xAA,0x55} (word0=0x55), mask=0; send 0x55,0x55,0xAA -> seq_idx goes 1,1,0, and UARTtrig fires once on the third word.
- PARITY_EN=1, even parity; send 0x03 with parity bit 1 -> parity_err pulse, no rx_rdy, seq_idx=0. Resend with parity bit 0 -> rx_rdy.
- Frame 0x55 with the stop bit driven low -> frame_err pulse, rx_data unchanged, matcher reset. The next frame is received normally.
- RX low pulse of bd/4 clocks -> no outputs, FSM back in IDLE. Change baud_cnt 16 -> 32 mid-frame -> the current word is still received correctly at 16.
- armed=0 during a matching sequence -> no UARTtrig, seq_idx=0. Assert rst_n low mid-frame -> all outputs at reset values and the next frame is received cleanly.
